// File: rtl/aes_cipher_masked3_if.sv
// Share/randomness bus of the 3-share masked AES-128 core.
// The master drives the plaintext, key and randomness shares; the slave
// returns the ciphertext shares and the done flag.
interface aes_cipher_masked3_if;
    logic         load;
    logic [127:0] InputData0;
    logic [127:0] InputData1;
    logic [127:0] InputData2;
    logic [127:0] Key0;
    logic [127:0] Key1;
    logic [127:0] Key2;
    logic [138:0] Static_r;
    logic [63:0]  Dynamic_r;
    logic [39:0]  Guards;
    logic [127:0] OutputData0;
    logic [127:0] OutputData1;
    logic [127:0] OutputData2;
    logic         done;

    modport master (
        output load, InputData0, InputData1, InputData2, Key0, Key1, Key2,
        output Static_r, Dynamic_r, Guards,
        input  OutputData0, OutputData1, OutputData2, done
    );

    modport slave (
        input  load, InputData0, InputData1, InputData2, Key0, Key1, Key2,
        input  Static_r, Dynamic_r, Guards,
        output OutputData0, OutputData1, OutputData2, done
    );
endinterface

// File: rtl/aes_cipher_masked3.sv
// Second-order (3-share) masked AES-128 encryption core.
// Ten blocks circulate in a 10-slot ring; each cycle the oldest slot goes
// through one full masked round and re-enters at slot 0, so one pass of the
// ring is one AES round for every block. The round key is derived on shares
// from the previous one and committed once per pass.
// The masked S-box computes x^254 with four 3-share domain-oriented
// multiplications; squarings and the affine map are linear and act per share.
module aes_cipher_masked3 (
    input  logic                    clk,
    input  logic                    rst,
    aes_cipher_masked3_if.slave     bus
);
    typedef logic [2:0][127:0] shares_t;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_OUT} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Share-wise repeated squaring (squaring is linear in GF(2^8)).
    function automatic logic [23:0] sq_n(input logic [23:0] a, input int n);
        logic [23:0] v;
        v = a;
        for (int k = 0; k < n; k++)
            for (int s = 0; s < 3; s++) v[8*s +: 8] = gf_mul(v[8*s +: 8], v[8*s +: 8]);
        return v;
    endfunction

    // 3-share multiplication; each cross-domain pair is refreshed by one random byte.
    function automatic logic [23:0] dom_mul(input logic [23:0] a, input logic [23:0] b,
                                            input logic [23:0] r);
        logic [7:0] c0, c1, c2;
        c0 = gf_mul(a[7:0], b[7:0]) ^ (gf_mul(a[7:0], b[15:8]) ^ r[7:0])
           ^ (gf_mul(a[7:0], b[23:16]) ^ r[15:8]);
        c1 = gf_mul(a[15:8], b[15:8]) ^ (gf_mul(a[15:8], b[7:0]) ^ r[7:0])
           ^ (gf_mul(a[15:8], b[23:16]) ^ r[23:16]);
        c2 = gf_mul(a[23:16], b[23:16]) ^ (gf_mul(a[23:16], b[7:0]) ^ r[15:8])
           ^ (gf_mul(a[23:16], b[15:8]) ^ r[23:16]);
        return {c2, c1, c0};
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [15:0] bb;
        bb = {b, b};
        return b ^ bb[14:7] ^ bb[13:6] ^ bb[12:5] ^ bb[11:4];
    endfunction

    // x^254 via x^2 -> x^3 -> x^12 -> x^15 -> x^240 -> x^252 -> x^254, then affine.
    function automatic logic [23:0] masked_sbox(input logic [23:0] x, input logic [95:0] r);
        logic [23:0] x2, x3, x12, x15, x240, x252, x254, y;
        x2   = sq_n(x, 1);
        x3   = dom_mul(x2, x, r[23:0]);
        x12  = sq_n(x3, 2);
        x15  = dom_mul(x12, x3, r[47:24]);
        x240 = sq_n(x15, 4);
        x252 = dom_mul(x240, x12, r[71:48]);
        x254 = dom_mul(x252, x2, r[95:72]);
        for (int s = 0; s < 3; s++) y[8*s +: 8] = affine(x254[8*s +: 8]);
        y[7:0] = y[7:0] ^ 8'h63;
        return y;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a3, a2, a1, a0} = c;
        return {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    shares_t      ring_reg [10];
    shares_t      key_reg;
    shares_t      out_reg;
    logic         done_reg;
    logic [3:0]   phase_reg;
    logic [3:0]   round_reg;
    state_t       state_reg, state_next;
    logic         do_round, do_emit;

    shares_t      sub_st, sr_st, mc_st, next_slot, rk;
    logic [2:0][31:0] key_temp;
    logic [23:0]  sb_out [20];
    logic [242:0] rnd_pool;

    assign rnd_pool = {bus.Static_r, bus.Dynamic_r, bus.Guards};

    // 16 state S-boxes on the oldest slot, 4 key-schedule S-boxes on RotWord(w3);
    // each S-box draws its 96 mask bits from a different window of the pool.
    for (genvar gi = 0; gi < 20; gi++) begin : gen_sbox
        localparam int OFF = gi * 147 / 19;
        logic [23:0] sb_in;
        if (gi < 16) begin : g_state
            assign sb_in = {ring_reg[9][2][8*gi +: 8], ring_reg[9][1][8*gi +: 8],
                            ring_reg[9][0][8*gi +: 8]};
        end else begin : g_key
            localparam int KB = 12 + ((gi - 15) % 4);
            assign sb_in = {key_reg[2][8*KB +: 8], key_reg[1][8*KB +: 8], key_reg[0][8*KB +: 8]};
        end
        assign sb_out[gi] = masked_sbox(sb_in, rnd_pool[OFF +: 96]);
    end

    // One masked round on the oldest slot: ShiftRows, MixColumns (not in round 10), AddRoundKey.
    always_comb begin
        sub_st    = '0;
        sr_st     = '0;
        mc_st     = '0;
        next_slot = '0;
        for (int i = 0; i < 16; i++)
            for (int s = 0; s < 3; s++) sub_st[s][8*i +: 8] = sb_out[i][8*s +: 8];
        for (int s = 0; s < 3; s++)
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    sr_st[s][8*(4*c+r) +: 8] = sub_st[s][8*(4*((c+r)%4)+r) +: 8];
        for (int s = 0; s < 3; s++)
            for (int c = 0; c < 4; c++)
                mc_st[s][32*c +: 32] = (round_reg == 4'd10) ? sr_st[s][32*c +: 32]
                                                            : mix_col(sr_st[s][32*c +: 32]);
        for (int s = 0; s < 3; s++) next_slot[s] = mc_st[s] ^ rk[s];
    end

    // Next round key on shares; Rcon enters share 0 only.
    always_comb begin
        logic [31:0] w;
        key_temp = '0;
        rk       = '0;
        for (int s = 0; s < 3; s++)
            for (int j = 0; j < 4; j++) key_temp[s][8*j +: 8] = sb_out[16+j][8*s +: 8];
        key_temp[0][7:0] = key_temp[0][7:0] ^ rcon(round_reg);
        for (int s = 0; s < 3; s++) begin
            w = key_temp[s];
            for (int j = 0; j < 4; j++) begin
                w = key_reg[s][32*j +: 32] ^ w;
                rk[s][32*j +: 32] = w;
            end
        end
    end

    // Control: load always wins; a run starts on the first edge without load.
    always_comb begin
        state_next = state_reg;
        do_round   = 1'b0;
        do_emit    = 1'b0;
        if (bus.load) begin
            state_next = ST_LOAD;
        end else begin
            case (state_reg)
                ST_LOAD, ST_RUN: begin
                    do_round   = 1'b1;
                    state_next = (round_reg == 4'd10 && phase_reg == 4'd9) ? ST_OUT : ST_RUN;
                end
                ST_OUT: begin
                    do_emit = 1'b1;
                    if (phase_reg == 4'd9) state_next = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    // Ring, key, counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 10; i++) ring_reg[i] <= '0;
            key_reg   <= '0;
            out_reg   <= '0;
            done_reg  <= 1'b0;
            phase_reg <= '0;
            round_reg <= 4'd1;
        end else if (bus.load) begin
            for (int i = 9; i > 0; i--) ring_reg[i] <= ring_reg[i-1];
            ring_reg[0][0] <= bus.InputData0 ^ bus.Key0;
            ring_reg[0][1] <= bus.InputData1 ^ bus.Key1;
            ring_reg[0][2] <= bus.InputData2 ^ bus.Key2;
            key_reg[0] <= bus.Key0;
            key_reg[1] <= bus.Key1;
            key_reg[2] <= bus.Key2;
            phase_reg  <= '0;
            round_reg  <= 4'd1;
            done_reg   <= 1'b0;
        end else if (do_round) begin
            for (int i = 9; i > 0; i--) ring_reg[i] <= ring_reg[i-1];
            ring_reg[0] <= next_slot;
            if (phase_reg == 4'd9) begin
                phase_reg <= '0;
                round_reg <= round_reg + 4'd1;
                key_reg   <= rk;
            end else begin
                phase_reg <= phase_reg + 4'd1;
            end
        end else if (do_emit) begin
            for (int i = 9; i > 0; i--) ring_reg[i] <= ring_reg[i-1];
            ring_reg[0] <= ring_reg[9];
            out_reg     <= ring_reg[9];
            done_reg    <= 1'b1;
            phase_reg   <= (phase_reg == 4'd9) ? 4'd0 : phase_reg + 4'd1;
        end else begin
            done_reg <= 1'b0;
        end
    end

    assign bus.OutputData0 = out_reg[0];
    assign bus.OutputData1 = out_reg[1];
    assign bus.OutputData2 = out_reg[2];
    assign bus.done        = done_reg;
endmodule

// File: tb/tb_aes_cipher_masked3.sv
// Self-checking bench for aes_cipher_masked3: a plain byte-array AES-128 model
// predicts the recombined ciphertext stream and the done window every cycle.
`timescale 1ns/1ps
module tb_aes_cipher_masked3;
    logic clk = 1'b0;
    logic rst = 1'b0;
    aes_cipher_masked3_if bus();

    aes_cipher_masked3 dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;
    bit rnd_on = 1'b0;

    logic [7:0]   sbox_t [256];
    logic [127:0] spec_pt [10];
    localparam logic [127:0] FIPS_KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 0; aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] st [16];
        logic [7:0] rk [16];
        logic [7:0] tmp [16];
        logic [7:0] t [4];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            st[i] = pt[8*i +: 8] ^ key[8*i +: 8];
            rk[i] = key[8*i +: 8];
        end
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            t[0] = sbox_t[rk[13]] ^ rc; t[1] = sbox_t[rk[14]];
            t[2] = sbox_t[rk[15]];      t[3] = sbox_t[rk[12]];
            for (int i = 0; i < 16; i++) begin
                if (i < 4) rk[i] = rk[i] ^ t[i];
                else       rk[i] = rk[i] ^ rk[i-4];
            end
            rc = gmul(rc, 8'h02);
            for (int i = 0; i < 16; i++) tmp[i] = sbox_t[st[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[4*c+r] = tmp[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                    st[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[i];
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = st[i];
        return res;
    endfunction

    // ---------------- behavioural model ----------------
    logic [127:0] burst [$];
    bit           prev_load = 1'b0;
    bit           m_active  = 1'b0;
    int           m_edges   = 0;
    logic [127:0] exp_out   = '0;
    bit           exp_known = 1'b1;
    bit           exp_done  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst.delete();
            prev_load = 0; m_active = 0; m_edges = 0;
            exp_out = '0; exp_known = 1; exp_done = 0;
        end else if (bus.load) begin
            if (!prev_load) burst.delete();
            burst.push_back(aes_enc(bus.InputData0 ^ bus.InputData1 ^ bus.InputData2,
                                    bus.Key0 ^ bus.Key1 ^ bus.Key2));
            if (burst.size() > 10) void'(burst.pop_front());
            m_active = 1; m_edges = 0; exp_done = 0;
            prev_load = 1;
        end else begin
            prev_load = 0;
            if (m_active) begin
                m_edges++;
                if (m_edges >= 101 && m_edges <= 110) begin
                    int k, n;
                    k = m_edges - 101;
                    n = burst.size();
                    exp_done = 1;
                    if (k >= 10 - n) begin
                        exp_out   = burst[k - (10 - n)];
                        exp_known = 1;
                    end else begin
                        exp_known = 0;
                    end
                end else if (m_edges == 111) begin
                    exp_done = 0;
                    m_active = 0;
                end
            end
        end
    end

    // Compare process: done every cycle, recombined data whenever it is defined.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("done", 128'(bus.done), 128'(exp_done));
            if (exp_known)
                check("cipher", bus.OutputData0 ^ bus.OutputData1 ^ bus.OutputData2, exp_out);
        end
    end

    // Fresh per-cycle randomness.
    always @(negedge clk) begin
        logic [63:0] g64;
        g64 = {$urandom(), $urandom()};
        bus.Dynamic_r = rnd_on ? {$urandom(), $urandom()} : 64'h0;
        bus.Guards    = rnd_on ? g64[39:0] : 40'h0;
    end

    task automatic drive_block(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s1, s2, k1, k2;
        s1 = rnd_on ? rand128() : '0;
        s2 = rnd_on ? rand128() : '0;
        k1 = rnd_on ? rand128() : '0;
        k2 = rnd_on ? rand128() : '0;
        bus.InputData0 = pt ^ s1 ^ s2; bus.InputData1 = s1; bus.InputData2 = s2;
        bus.Key0 = key ^ k1 ^ k2;      bus.Key1 = k1;       bus.Key2 = k2;
        bus.load = 1'b1;
    endtask

    // mode 0: FIPS plaintext repeated, 1: specified list, 2: random plaintexts.
    task automatic load_burst(input int n, input int mode, input logic [127:0] key);
        logic [159:0] st160;
        logic [127:0] pt;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                st160 = {rand128(), $urandom()};
                bus.Static_r = rnd_on ? st160[138:0] : '0;
            end
            pt = (mode == 0) ? spec_pt[0] : (mode == 1) ? spec_pt[i % 10] : rand128();
            drive_block(pt, key);
        end
        @(negedge clk);
        bus.load = 1'b0;
        bus.InputData0 = rand128();
        bus.Key0       = rand128();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] inv, s, c63;
        logic [127:0] key_r;
        bus.load = 0;
        bus.InputData0 = '0; bus.InputData1 = '0; bus.InputData2 = '0;
        bus.Key0 = '0; bus.Key1 = '0; bus.Key2 = '0;
        bus.Static_r = '0; bus.Dynamic_r = '0; bus.Guards = '0;

        c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c63[b];
            sbox_t[x] = s;
        end

        spec_pt[0] = 128'h340737e0a29831318d305a88a8f64332;
        spec_pt[1] = 128'h0;
        spec_pt[2] = 128'h0123456789abcdef0123456789abcdef;
        spec_pt[3] = 128'h00112233445566778899aabbccddeeff;
        spec_pt[4] = 128'h340737e0a29831318d305a88a8f64332;
        spec_pt[5] = 128'h99a3b83af1cc35ae5abb54fdfcae9a7a;
        spec_pt[6] = 128'h98b7f0cdab31bd08a87578c5e898277a;
        spec_pt[7] = 128'h68799cfef8bb24f5365ddf0b896283eb;
        spec_pt[8] = 128'h3bdfeda677b8225724bcd2eb1593d76e;
        spec_pt[9] = 128'h4b52a4f3c66b51ebc9c7950820e1d3cf;

        // Pin the model to known values.
        check("model_sbox00", 128'(sbox_t[0]), 128'h63);
        check("model_sbox53", 128'(sbox_t[8'h53]), 128'hed);
        check("model_fips", aes_enc(spec_pt[0], FIPS_KEY), 128'h320b6a19978511dcfb09dc021d842539);
        check("model_zero", aes_enc(spec_pt[1], FIPS_KEY), 128'h6f541bb947f0423eb399b81a0c6bf77d);
        check("model_pt3",  aes_enc(spec_pt[3], FIPS_KEY), 128'hc1b8350e659b5d432f1bb87a1c67492f);
        check("model_pt9",  aes_enc(spec_pt[9], FIPS_KEY), 128'h963e2febb8560f31a2305a8db95aecf6);

        // Reset state.
        cmp_en = 1;
        idle(3);
        check("reset_out", bus.OutputData0 | bus.OutputData1 | bus.OutputData2, 128'h0);
        check("reset_done", 128'(bus.done), 128'h0);
        rst = 1'b1;
        idle(2);

        // FIPS block loaded 20 cycles, no masking randomness at all.
        rnd_on = 0;
        load_burst(20, 0, FIPS_KEY);
        idle(115);
        check("fips_hold", bus.OutputData0 ^ bus.OutputData1 ^ bus.OutputData2,
              128'h320b6a19978511dcfb09dc021d842539);

        // Specified plaintext list under random shares and randomness.
        rnd_on = 1;
        load_burst(10, 1, FIPS_KEY);
        idle(115);

        // Random key and plaintexts.
        key_r = rand128();
        load_burst(10, 2, key_r);
        idle(115);

        // Load during the round passes aborts the run.
        load_burst(10, 2, key_r);
        idle(40);
        load_burst(12, 2, key_r);
        idle(115);

        // Load during the output window aborts it.
        key_r = rand128();
        load_burst(10, 2, key_r);
        idle(105);
        load_burst(10, 1, FIPS_KEY);
        idle(115);

        // Short burst: only the last 4 results are defined.
        load_burst(4, 2, key_r);
        idle(115);

        // Asynchronous reset in the middle of a run.
        load_burst(10, 2, key_r);
        repeat (50) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_sh0", bus.OutputData0, 128'h0);
        check("midrst_sh1", bus.OutputData1, 128'h0);
        check("midrst_sh2", bus.OutputData2, 128'h0);
        check("midrst_done", 128'(bus.done), 128'h0);
        @(negedge clk);
        rst = 1'b1;
        idle(150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
